reaction_timer_core: RTL and testbench
======================================

Name: reaction_timer_core

Overview:
- Game-logic stage of the reaction-time game.
- Consumes raw push-buttons and the 100 ms tick pulse from the clock divider.
- Produces BCD tens/ones digits for the dual seven-segment display driver (codes above 9 display blank), plus a "go" indicator.
- Contains the button synchronisers/debouncers, a random-delay LFSR and the round state machine.

Parameters:
- DEB_CYCLES, 16: consecutive clocks a synchronised button level must hold before the debounced level follows it.
- MIN_DELAY, 10: minimum tick count in WAIT (10 ticks = 1.0 s).

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- tick  in  1  one-cycle pulse every 100 ms, synchronous to clk
- start_btn  in  1  raw asynchronous start button, active high
- react_btn  in  1  raw asynchronous reaction button, active high
- tens  out  4  BCD tens digit to display driver
- ones  out  4  BCD ones digit to display driver
- go  out  1  high while the player should react
- state_o  out  3  current FSM state encoding
- overflow  out  1  round ended by saturation at 99

Behaviour:
- One clock domain. Reset is synchronous and active-low (clk, rst_n). All flops are updated only on posedge clk.
- Reset values:
  - state IDLE (0)
  - tens = ones = 4'hF
  - go = 0, overflow = 0
  - LFSR = 8'hA5
  - synchronisers and debounced levels = 0; debounce counters = 0
- Input conditioning, per button:
  - 2-FF synchroniser.
  - Debounce counter: increments while synced level != debounced level, clears otherwise. When it reaches DEB_CYCLES, the debounced level toggles and the counter clears.
  - Press pulse: one cycle wide, registered from (debounced & ~debounced_d).
  - Latency: if the raw input rises and stays high, the press pulse asserts exactly DEB_CYCLES+3 clocks after the first edge that samples it high.
  - Glitches shorter than DEB_CYCLES produce no pulse. Release produces no pulse.
- LFSR:
  - 8-bit Fibonacci, free-running every clock, including during reset release.
  - Update: next = {l[6:0], l[7]^l[5]^l[4]^l[3]}. Never reaches zero.
- FSM states:
  - IDLE = 0, WAIT = 1, RUN = 2, DONE = 3, FOUL = 4. state_o reflects the registered state.
- IDLE:
  - tens/ones = F/F, go = 0.
  - start press -> WAIT; latch delay = MIN_DELAY + l[4:0] (range MIN_DELAY..MIN_DELAY+31); clear overflow.
- WAIT:
  - Display F/F, go = 0.
  - Each tick decrements delay. A tick that takes delay from 1 to 0 moves to RUN next cycle, with tens = ones = 0 and go = 1.
  - react press -> FOUL. If a press and the final tick occur in the same cycle, FOUL wins.
- RUN:
  - go = 1.
  - Each tick increments ones; ones 9 -> 0 carries into tens.
  - A tick at 9/9 leaves the display at 9/9, sets overflow = 1 and moves to DONE.
  - react press -> DONE with the display frozen. If a press and a tick coincide, the press wins and the tick is not counted.
- DONE:
  - go = 0, display holds the final value, overflow holds.
  - start press -> WAIT (new round, new delay latched, overflow cleared).
- FOUL:
  - go = 0, tens = ones = 4'hE (blank on the display; distinct code for the bench).
  - start press -> WAIT as from DONE.
- Ignored inputs:
  - start presses in WAIT and RUN are ignored.
  - react presses in IDLE, DONE and FOUL are ignored.
- tick has no effect in IDLE, DONE or FOUL.
- rst_n low in any state, mid-round included: on the next edge the block returns to all reset values. Any press in flight is discarded.

Test Plan (DEB_CYCLES=4, MIN_DELAY=2, tick every 10 clocks):
- Debounce: react_btn high for 3 clocks, then low -> no press pulse. Held high -> exactly one pulse, 7 clocks after the first high sample.
- Normal round:
  - Reset, then start held. Expect state WAIT with delay = 2 + (LFSR[4:0] at latch); WAIT must last that many ticks.
  - Expect go = 1 and display 0/0 in RUN.
  - Press react after 23 ticks -> DONE, tens = 2, ones = 3, go = 0, overflow = 0.
- Foul: react press during WAIT -> state FOUL, tens = ones = 4'hE, go = 0. Then start -> WAIT.
- Saturation: no react in RUN for 100 ticks -> after the 99th tick display 9/9; the 100th tick -> DONE with overflow = 1, display 9/9.
- Simultaneous: press pulse in the same cycle as a tick in RUN at 0/4 -> DONE showing 0/4. Press coinciding with the final WAIT tick -> FOUL.
- Mid-round reset: rst_n low for 1 clock while in RUN at 3/7 -> next cycle IDLE, F/F, go = 0, overflow = 0, LFSR = 8'hA5.

Source files
------------

// File: rtl/reaction_timer_core.sv
// Game-logic stage of the reaction-time game: button conditioning, random delay
// source and the round state machine driving the two BCD display digits.
module reaction_timer_core #(
  parameter int DEB_CYCLES = 16,
  parameter int MIN_DELAY  = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       start_btn,
  input  logic       react_btn,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       go,
  output logic [2:0] state_o,
  output logic       overflow
);

  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam int DW = $clog2(MIN_DELAY + 32);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WAIT = 3'd1,
    RUN  = 3'd2,
    DONE = 3'd3,
    FOUL = 3'd4
  } state_t;

  state_t        state;
  logic [1:0]    btn_raw;
  logic [1:0]    sync1;
  logic [1:0]    sync2;
  logic [1:0]    deb;
  logic [1:0]    deb_d;
  logic [1:0]    press;
  logic [CW-1:0] deb_cnt [2];
  logic [7:0]    lfsr;
  logic [DW-1:0] delay;
  logic          start_press;
  logic          react_press;

  assign btn_raw     = {react_btn, start_btn};
  assign start_press = press[0];
  assign react_press = press[1];
  assign state_o     = state;

  // Bit 0 is the start button, bit 1 the react button. The debounced level only
  // flips after the counter has sat at DEB_CYCLES with the synced level still different.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      deb_d <= '0;
      press <= '0;
      for (int i = 0; i < 2; i++) deb_cnt[i] <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      deb_d <= deb;
      press <= deb & ~deb_d;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] != deb[i]) begin
          if (deb_cnt[i] == CW'(DEB_CYCLES)) begin
            deb[i]     <= ~deb[i];
            deb_cnt[i] <= '0;
          end else begin
            deb_cnt[i] <= deb_cnt[i] + CW'(1);
          end
        end else begin
          deb_cnt[i] <= '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) lfsr <= 8'hA5;
    else        lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

  // Display codes: F/F while idle or waiting, E/E after a foul.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      tens     <= 4'hF;
      ones     <= 4'hF;
      go       <= 1'b0;
      overflow <= 1'b0;
      delay    <= '0;
    end else begin
      case (state)
        IDLE, DONE, FOUL: begin
          if (start_press) begin
            state    <= WAIT;
            delay    <= DW'(MIN_DELAY) + DW'(lfsr[4:0]);
            overflow <= 1'b0;
            tens     <= 4'hF;
            ones     <= 4'hF;
            go       <= 1'b0;
          end
        end
        WAIT: begin
          if (react_press) begin
            state <= FOUL;
            tens  <= 4'hE;
            ones  <= 4'hE;
            go    <= 1'b0;
          end else if (tick) begin
            if (delay <= DW'(1)) begin
              state <= RUN;
              tens  <= 4'h0;
              ones  <= 4'h0;
              go    <= 1'b1;
            end else begin
              delay <= delay - DW'(1);
            end
          end
        end
        RUN: begin
          if (react_press) begin
            state <= DONE;
            go    <= 1'b0;
          end else if (tick) begin
            if (tens == 4'd9 && ones == 4'd9) begin
              state    <= DONE;
              overflow <= 1'b1;
              go       <= 1'b0;
            end else if (ones == 4'd9) begin
              ones <= 4'd0;
              tens <= tens + 4'd1;
            end else begin
              ones <= ones + 4'd1;
            end
          end
        end
        default: begin
          state <= IDLE;
          tens  <= 4'hF;
          ones  <= 4'hF;
          go    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reaction_timer_core.sv
// Directed bench for reaction_timer_core with DEB_CYCLES=4, MIN_DELAY=2 and a
// tick every 10 clocks.
module tb_reaction_timer_core;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WAIT = 3'd1;
  localparam logic [2:0] S_RUN  = 3'd2;
  localparam logic [2:0] S_DONE = 3'd3;
  localparam logic [2:0] S_FOUL = 3'd4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic       start_btn = 1'b0;
  logic       react_btn = 1'b0;
  logic [3:0] tens;
  logic [3:0] ones;
  logic       go;
  logic [2:0] state_o;
  logic       overflow;

  int errors = 0;
  int checks = 0;
  int exp_delay = 0;

  logic [7:0] m_lfsr;
  logic [7:0] m_prev;

  reaction_timer_core #(.DEB_CYCLES(4), .MIN_DELAY(2)) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .start_btn(start_btn), .react_btn(react_btn),
    .tens(tens), .ones(ones), .go(go), .state_o(state_o), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Reference LFSR; m_prev holds the value the DUT saw before the latest edge.
  always @(posedge clk) begin
    if (!rst_n) m_lfsr <= 8'hA5;
    else        m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    m_prev <= m_lfsr;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic give_ticks(input int n);
    repeat (n) begin
      tick = 1'b1;
      step();
      tick = 1'b0;
      repeat (9) step();
    end
  endtask

  // Press pulse is high after the 8th edge; the FSM reacts on the 9th.
  task automatic do_press(input bit which, input bit with_tick);
    if (which) react_btn = 1'b1;
    else       start_btn = 1'b1;
    repeat (8) step();
    tick = with_tick;
    step();
    tick = 1'b0;
    start_btn = 1'b0;
    react_btn = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) step();
    checks++; if (state_o !== S_IDLE) begin errors++; $display("[TB] FAIL reset_state: got %0d want %0d", state_o, S_IDLE); end
    checks++; if (tens !== 4'hF || ones !== 4'hF) begin errors++; $display("[TB] FAIL reset_digits: got %h/%h want f/f", tens, ones); end
    checks++; if (go !== 1'b0 || overflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_flags: go=%b ovf=%b want 0/0", go, overflow); end
    checks++; if (dut.lfsr !== 8'hA5) begin errors++; $display("[TB] FAIL reset_lfsr: got %h want a5", dut.lfsr); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_debounce();
    start_btn = 1'b1;
    repeat (8) step();
    checks++; if (state_o !== S_IDLE) begin errors++; $display("[TB] FAIL deb_early: got %0d want %0d", state_o, S_IDLE); end
    step();
    checks++; if (state_o !== S_WAIT) begin errors++; $display("[TB] FAIL deb_latency: got %0d want %0d", state_o, S_WAIT); end
    start_btn = 1'b0;
    repeat (15) step();
    react_btn = 1'b1;
    repeat (3) step();
    react_btn = 1'b0;
    repeat (15) step();
    checks++; if (state_o !== S_WAIT) begin errors++; $display("[TB] FAIL deb_glitch: got %0d want %0d", state_o, S_WAIT); end
    react_btn = 1'b1;
    repeat (8) step();
    checks++; if (state_o !== S_WAIT) begin errors++; $display("[TB] FAIL foul_early: got %0d want %0d", state_o, S_WAIT); end
    step();
    checks++; if (state_o !== S_FOUL) begin errors++; $display("[TB] FAIL foul_state: got %0d want %0d", state_o, S_FOUL); end
    checks++; if (tens !== 4'hE || ones !== 4'hE || go !== 1'b0) begin errors++; $display("[TB] FAIL foul_display: got %h/%h go=%b want e/e go=0", tens, ones, go); end
    react_btn = 1'b0;
    repeat (12) step();
  endtask

  task automatic test_normal_round();
    do_press(1'b0, 1'b0);
    exp_delay = 2 + int'(m_prev[4:0]);
    checks++; if (state_o !== S_WAIT || tens !== 4'hF || ones !== 4'hF || go !== 1'b0) begin errors++; $display("[TB] FAIL round_start: state=%0d %h/%h go=%b want 1 f/f go=0", state_o, tens, ones, go); end
    give_ticks(exp_delay - 1);
    checks++; if (state_o !== S_WAIT) begin errors++; $display("[TB] FAIL round_wait_len: got %0d want %0d (delay %0d)", state_o, S_WAIT, exp_delay); end
    give_ticks(1);
    checks++; if (state_o !== S_RUN || tens !== 4'd0 || ones !== 4'd0 || go !== 1'b1) begin errors++; $display("[TB] FAIL round_run: state=%0d %h/%h go=%b want 2 0/0 go=1", state_o, tens, ones, go); end
    give_ticks(23);
    checks++; if (state_o !== S_RUN || tens !== 4'd2 || ones !== 4'd3) begin errors++; $display("[TB] FAIL round_count: state=%0d %h/%h want 2 2/3", state_o, tens, ones); end
    do_press(1'b0, 1'b0);
    checks++; if (state_o !== S_RUN || tens !== 4'd2 || ones !== 4'd3) begin errors++; $display("[TB] FAIL start_in_run: state=%0d %h/%h want 2 2/3", state_o, tens, ones); end
    do_press(1'b1, 1'b0);
    checks++; if (state_o !== S_DONE || tens !== 4'd2 || ones !== 4'd3) begin errors++; $display("[TB] FAIL round_done: state=%0d %h/%h want 3 2/3", state_o, tens, ones); end
    checks++; if (go !== 1'b0 || overflow !== 1'b0) begin errors++; $display("[TB] FAIL round_done_flags: go=%b ovf=%b want 0/0", go, overflow); end
    give_ticks(2);
    checks++; if (state_o !== S_DONE || tens !== 4'd2 || ones !== 4'd3) begin errors++; $display("[TB] FAIL done_tick: state=%0d %h/%h want 3 2/3", state_o, tens, ones); end
  endtask

  task automatic test_saturation();
    do_press(1'b0, 1'b0);
    exp_delay = 2 + int'(m_prev[4:0]);
    checks++; if (state_o !== S_WAIT || tens !== 4'hF || ones !== 4'hF) begin errors++; $display("[TB] FAIL sat_start: state=%0d %h/%h want 1 f/f", state_o, tens, ones); end
    give_ticks(exp_delay);
    checks++; if (state_o !== S_RUN) begin errors++; $display("[TB] FAIL sat_run: got %0d want %0d", state_o, S_RUN); end
    give_ticks(99);
    checks++; if (state_o !== S_RUN || tens !== 4'd9 || ones !== 4'd9 || overflow !== 1'b0) begin errors++; $display("[TB] FAIL sat_99: state=%0d %h/%h ovf=%b want 2 9/9 ovf=0", state_o, tens, ones, overflow); end
    give_ticks(1);
    checks++; if (state_o !== S_DONE || tens !== 4'd9 || ones !== 4'd9) begin errors++; $display("[TB] FAIL sat_done: state=%0d %h/%h want 3 9/9", state_o, tens, ones); end
    checks++; if (overflow !== 1'b1 || go !== 1'b0) begin errors++; $display("[TB] FAIL sat_flags: ovf=%b go=%b want 1/0", overflow, go); end
    do_press(1'b1, 1'b0);
    checks++; if (state_o !== S_DONE || overflow !== 1'b1) begin errors++; $display("[TB] FAIL react_in_done: state=%0d ovf=%b want 3 ovf=1", state_o, overflow); end
  endtask

  task automatic test_simultaneous();
    do_press(1'b0, 1'b0);
    exp_delay = 2 + int'(m_prev[4:0]);
    checks++; if (state_o !== S_WAIT || overflow !== 1'b0) begin errors++; $display("[TB] FAIL ovf_clear: state=%0d ovf=%b want 1 ovf=0", state_o, overflow); end
    give_ticks(exp_delay + 4);
    checks++; if (state_o !== S_RUN || tens !== 4'd0 || ones !== 4'd4) begin errors++; $display("[TB] FAIL sim_pre: state=%0d %h/%h want 2 0/4", state_o, tens, ones); end
    do_press(1'b1, 1'b1);
    checks++; if (state_o !== S_DONE || tens !== 4'd0 || ones !== 4'd4) begin errors++; $display("[TB] FAIL sim_run_press: state=%0d %h/%h want 3 0/4", state_o, tens, ones); end
    do_press(1'b0, 1'b0);
    exp_delay = 2 + int'(m_prev[4:0]);
    give_ticks(exp_delay - 1);
    checks++; if (state_o !== S_WAIT) begin errors++; $display("[TB] FAIL sim_wait_pre: got %0d want %0d", state_o, S_WAIT); end
    do_press(1'b1, 1'b1);
    checks++; if (state_o !== S_FOUL || tens !== 4'hE || ones !== 4'hE) begin errors++; $display("[TB] FAIL sim_wait_press: state=%0d %h/%h want 4 e/e", state_o, tens, ones); end
  endtask

  task automatic test_mid_reset();
    do_press(1'b0, 1'b0);
    exp_delay = 2 + int'(m_prev[4:0]);
    give_ticks(exp_delay + 37);
    checks++; if (state_o !== S_RUN || tens !== 4'd3 || ones !== 4'd7) begin errors++; $display("[TB] FAIL mid_pre: state=%0d %h/%h want 2 3/7", state_o, tens, ones); end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    checks++; if (state_o !== S_IDLE || tens !== 4'hF || ones !== 4'hF) begin errors++; $display("[TB] FAIL mid_reset: state=%0d %h/%h want 0 f/f", state_o, tens, ones); end
    checks++; if (go !== 1'b0 || overflow !== 1'b0 || dut.lfsr !== 8'hA5) begin errors++; $display("[TB] FAIL mid_reset_flags: go=%b ovf=%b lfsr=%h want 0/0/a5", go, overflow, dut.lfsr); end
    repeat (12) step();
    do_press(1'b1, 1'b0);
    checks++; if (state_o !== S_IDLE) begin errors++; $display("[TB] FAIL react_in_idle: got %0d want %0d", state_o, S_IDLE); end
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_normal_round();
    test_saturation();
    test_simultaneous();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
